disp_scan_ctrl: RTL and testbench
=================================

# disp_scan_ctrl

Four-digit multiplexed display scan controller. It owns the 2-bit digit index, the per-digit on-time and the inter-digit blanking gap. It drives active-low digit anodes and selects the 4-bit nibble for the 7-segment decoder downstream. The displayed value, digit mask and suppression mode are latched once per frame, so a frame never mixes old and new data.

## Interface
- ON_CYC, default 50000: clock cycles a digit is lit; minimum 1.
- BLANK_CYC, default 1000: cycles with all anodes off between digits; 0 means no gap.
- Clk  in  1  system clock, all state on rising edge.
- Rst  in  1  reset; one clock; reset is asynchronous and active-high.
- Run  in  1  1 = scan, 0 = stop with display dark.
- Value  in  16  four BCD/hex nibbles; [3:0] = digit 0 (LSD), [15:12] = digit 3 (MSD).
- DigitEn  in  4  per-digit enable mask, bit k = digit k.
- LzSup  in  1  leading-zero suppression enable.
- Anodo  out  4  active-low one-hot digit select; 4'b1111 = all off.
- Nibble  out  4  nibble of the current digit.
- Sel  out  2  current digit index 0..3.
- FrameStart  out  1  one-cycle pulse when a new frame begins (shadow latched).

## Operation
- FSM states: STOP, ON, BLANK. Timer width = clog2(max(ON_CYC, BLANK_CYC)+1).
- Shadow registers sh_val[15:0], sh_en[3:0], sh_lz hold Value, DigitEn and LzSup. They load only on frame start (STOP->ON, or BLANK->ON with Sel wrapping 3->0).
- STOP: Anodo=1111, Sel=0. When Run=1 is sampled: go to ON, Sel=0, load the shadow, assert FrameStart.
- ON: hold for ON_CYC cycles. Then go to BLANK, or, if BLANK_CYC=0, go directly to the next digit's ON.
- BLANK: hold BLANK_CYC cycles. Then go to ON with Sel=Sel+1 mod 4. If the new Sel is 0, load the shadow and pulse FrameStart.
- Run=0 sampled in ON or BLANK: go to STOP at that edge. Sel->0, timer->0, FrameStart=0.
- Nibble = sh_val[4*Sel+3 : 4*Sel] in every state.
- Digit k is blanked if sh_en[k]=0. It is also blanked if sh_lz=1, k!=0 and all sh_val nibbles k..3 are zero. Digit 0 is never LZ-suppressed.
- Anodo: in ON, Anodo[Sel]=0 unless the digit is blanked; all other bits 1. In BLANK and STOP, Anodo=1111.
- All outputs are registered, or decoded only from registers (state, Sel, shadow). No input-to-output combinational path.
- Rst asserted at any time: immediately go to STOP, shadow=0, Sel=0, Anodo=1111, Nibble=0, FrameStart=0. Scanning resumes only on a Run=1 sample after Rst deasserts.

## Timing
- Run 0->1 sampled at edge N: from edge N, state=ON, Sel=0, FrameStart=1 for exactly one cycle, digit 0 lit.
- Digit period = ON_CYC + BLANK_CYC cycles. Frame = 4 x (ON_CYC + BLANK_CYC). FrameStart period equals one frame.
- Sel changes only on the BLANK->ON (or ON->ON when BLANK_CYC=0) edge. Never two anodes low in the same cycle.
- Input changes to Value/DigitEn/LzSup take effect at the next FrameStart. Latency is 0 to 1 frame.
- Run=0 -> Anodo=1111 one edge later. Run re-asserted restarts from digit 0 with a fresh FrameStart.

## Test plan
Bench parameters: ON_CYC=4, BLANK_CYC=2.
- Reset: assert Rst asynchronously mid-cycle -> Anodo=1111, Sel=0, Nibble=0, FrameStart=0 before the next edge.
- Basic scan, Value=16'h1234, DigitEn=4'hF, LzSup=0, Run=1:
  - Anodo sequence 1110 x4, 1111 x2, 1101 x4, 1111 x2, 1011 x4, 1111 x2, 0111 x4, 1111 x2, repeating.
  - Nibble=4,3,2,1 during the respective ON phases.
  - FrameStart pulses every 24 cycles.
- Tear-free update: change Value to 16'hABCD at cycle 10 of the frame -> digits 2 and 3 still show 2 and 1. Next frame shows D,C,B,A.
- Leading-zero suppression, LzSup=1:
  - Value=16'h0050 -> digits 3 and 2 stay 1111 during their ON slots, digit 1 shows 5, digit 0 shows 0.
  - Value=16'h0000 -> only digit 0 lit.
- Mask: DigitEn=4'b0101 -> Anodo[1] and Anodo[3] never 0. Frame timing unchanged at 24 cycles.
- Stop/restart and no-gap variant:
  - Run=0 during digit 2 ON -> Anodo=1111 and Sel=0 at the next edge.
  - Run=1 again -> digit 0 plus FrameStart at the following edge.
  - Rerun with BLANK_CYC=0 -> digits back-to-back, 16-cycle frame, no all-off cycle while running.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed display scan controller: digit on-time, inter-digit blanking,
// per-frame shadowing of value/mask/suppression, active-low anode drive.
module disp_scan_ctrl #(
  parameter int unsigned ON_CYC    = 50000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Run,
  input  logic [15:0] Value,
  input  logic [3:0]  DigitEn,
  input  logic        LzSup,
  output logic [3:0]  Anodo,
  output logic [3:0]  Nibble,
  output logic [1:0]  Sel,
  output logic        FrameStart
);

  localparam int unsigned MAX_CYC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
  localparam int unsigned TW      = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);
  localparam bit          NO_GAP  = (BLANK_CYC == 0);
  localparam logic [TW-1:0] ON_LAST    = TW'((ON_CYC == 0) ? 0 : ON_CYC - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_ON    = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [15:0]   sh_val;
  logic [3:0]    sh_en;
  logic          sh_lz;

  logic          on_done;
  logic          blank_done;
  logic          digit_done;
  logic          wrap;
  logic [3:0]    upper_zero;
  logic          digit_lit;

  // End of a digit slot: BLANK expiry, or ON expiry when there is no gap
  assign on_done    = (state == ST_ON)    && (timer == ON_LAST);
  assign blank_done = (state == ST_BLANK) && (timer == BLANK_LAST);
  assign digit_done = blank_done || (on_done && NO_GAP);
  assign wrap       = digit_done && (Sel == 2'd3);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= ST_STOP;
      timer      <= '0;
      Sel        <= 2'd0;
      FrameStart <= 1'b0;
      sh_val     <= 16'h0000;
      sh_en      <= 4'h0;
      sh_lz      <= 1'b0;
    end else begin
      FrameStart <= 1'b0;
      if (!Run) begin
        state <= ST_STOP;
        timer <= '0;
        Sel   <= 2'd0;
      end else begin
        case (state)
          ST_STOP: begin
            state      <= ST_ON;
            timer      <= '0;
            Sel        <= 2'd0;
            FrameStart <= 1'b1;
            sh_val     <= Value;
            sh_en      <= DigitEn;
            sh_lz      <= LzSup;
          end
          ST_ON, ST_BLANK: begin
            if (digit_done) begin
              state <= ST_ON;
              timer <= '0;
              Sel   <= Sel + 2'd1;
              if (wrap) begin
                FrameStart <= 1'b1;
                sh_val     <= Value;
                sh_en      <= DigitEn;
                sh_lz      <= LzSup;
              end
            end else if (on_done) begin
              state <= ST_BLANK;
              timer <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          default: begin
            state <= ST_STOP;
            timer <= '0;
            Sel   <= 2'd0;
          end
        endcase
      end
    end
  end

  // upper_zero[k]: nibbles k..3 of the shadowed value are all zero
  assign upper_zero[0] = (sh_val == 16'h0000);
  assign upper_zero[1] = (sh_val[15:4] == 12'h000);
  assign upper_zero[2] = (sh_val[15:8] == 8'h00);
  assign upper_zero[3] = (sh_val[15:12] == 4'h0);

  assign digit_lit = sh_en[Sel] && !(sh_lz && (Sel != 2'd0) && upper_zero[Sel]);

  assign Anodo  = ((state == ST_ON) && digit_lit) ? ~(4'b0001 << Sel) : 4'b1111;
  assign Nibble = sh_val[{Sel, 2'b00} +: 4];

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomized bench for disp_scan_ctrl: a gapped and a no-gap instance share inputs and are
// compared each cycle against a frame-position reference model.
module tb_disp_scan_ctrl;

  localparam int unsigned ON_C = 4;
  localparam int unsigned BL_C = 2;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Run;
  logic [15:0] Value;
  logic [3:0]  DigitEn;
  logic        LzSup;

  logic [3:0] anodo_g, nibble_g, anodo_n, nibble_n;
  logic [1:0] sel_g, sel_n;
  logic       fs_g, fs_n;

  int checks   = 0;
  int failures = 0;

  // Model state per instance: 0 = with blanking gap, 1 = no gap
  int unsigned per [2];
  bit          m_run [2];
  int unsigned m_t [2];
  logic [15:0] m_val [2];
  logic [3:0]  m_en [2];
  logic        m_lz [2];

  always #5 Clk = ~Clk;

  disp_scan_ctrl #(.ON_CYC(ON_C), .BLANK_CYC(BL_C)) u_gap (
    .Clk(Clk), .Rst(Rst), .Run(Run), .Value(Value), .DigitEn(DigitEn), .LzSup(LzSup),
    .Anodo(anodo_g), .Nibble(nibble_g), .Sel(sel_g), .FrameStart(fs_g)
  );

  disp_scan_ctrl #(.ON_CYC(ON_C), .BLANK_CYC(0)) u_nogap (
    .Clk(Clk), .Rst(Rst), .Run(Run), .Value(Value), .DigitEn(DigitEn), .LzSup(LzSup),
    .Anodo(anodo_n), .Nibble(nibble_n), .Sel(sel_n), .FrameStart(fs_n)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 1'b0;
      m_t[d]   = 0;
      m_val[d] = 16'h0000;
      m_en[d]  = 4'h0;
      m_lz[d]  = 1'b0;
    end
  endtask

  task automatic model_latch(input int d);
    m_val[d] = Value;
    m_en[d]  = DigitEn;
    m_lz[d]  = LzSup;
  endtask

  // One rising edge: t counts cycles since the scan started; a frame is 4 digit periods
  task automatic model_edge();
    if (Rst) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      if (!Run) begin
        m_run[d] = 1'b0;
        m_t[d]   = 0;
      end else if (!m_run[d]) begin
        m_run[d] = 1'b1;
        m_t[d]   = 0;
        model_latch(d);
      end else begin
        m_t[d]++;
        if (m_t[d] % (4 * per[d]) == 0) model_latch(d);
      end
    end
  endtask

  task automatic compare_dut(input int d, input logic [3:0] an, input logic [3:0] nib,
                             input logic [1:0] sel, input logic fs);
    int unsigned e_sel;
    bit          lit;
    logic [3:0]  e_an;
    logic [15:0] shifted;
    e_sel   = m_run[d] ? (m_t[d] / per[d]) % 4 : 0;
    shifted = m_val[d] >> (4 * e_sel);
    lit     = m_run[d] && ((m_t[d] % per[d]) < ON_C) && m_en[d][e_sel]
              && !(m_lz[d] && (e_sel != 0) && (shifted == 16'h0000));
    e_an    = lit ? ~(4'b0001 << e_sel) : 4'b1111;
    check($sformatf("anodo[%0d]", d), 16'(an), 16'(e_an));
    check($sformatf("nibble[%0d]", d), 16'(nib), 16'(shifted[3:0]));
    check($sformatf("sel[%0d]", d), 16'(sel), 16'(e_sel));
    check($sformatf("framestart[%0d]", d), 16'(fs),
          16'(m_run[d] && (m_t[d] % (4 * per[d]) == 0)));
    check($sformatf("onehot[%0d]", d), 16'($countones(~an) <= 1), 16'd1);
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    compare_dut(0, anodo_g, nibble_g, sel_g, fs_g);
    compare_dut(1, anodo_n, nibble_n, sel_n, fs_n);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) step();
  endtask

  // Reset asserted between edges must clear outputs before the next edge
  task automatic async_reset();
    #2 Rst = 1'b1;
    #1;
    model_reset();
    check("rst_anodo_g", 16'(anodo_g), 16'hF);
    check("rst_sel_g", 16'(sel_g), 16'h0);
    check("rst_nibble_g", 16'(nibble_g), 16'h0);
    check("rst_fs_g", 16'(fs_g), 16'h0);
    check("rst_anodo_n", 16'(anodo_n), 16'hF);
    check("rst_fs_n", 16'(fs_n), 16'h0);
    run_cycles(1);
    Rst = 1'b0;
  endtask

  initial begin
    per[0]  = ON_C + BL_C;
    per[1]  = ON_C;
    Rst     = 1'b1;
    Run     = 1'b0;
    Value   = 16'h0000;
    DigitEn = 4'hF;
    LzSup   = 1'b0;
    model_reset();
    run_cycles(2);
    Rst = 1'b0;
    run_cycles(2);

    // Basic scan, then a mid-frame value change that must not tear the frame
    Value = 16'h1234;
    Run   = 1'b1;
    run_cycles(34);
    Value = 16'hABCD;
    run_cycles(38);

    // Leading-zero suppression
    LzSup = 1'b1;
    Value = 16'h0050;
    run_cycles(48);
    Value = 16'h0000;
    run_cycles(48);

    // Digit mask
    LzSup   = 1'b0;
    Value   = 16'h9876;
    DigitEn = 4'b0101;
    run_cycles(48);

    // Stop during digit 2 ON, then restart
    DigitEn = 4'hF;
    Run     = 1'b0;
    run_cycles(2);
    Run = 1'b1;
    run_cycles(13);
    Run = 1'b0;
    run_cycles(3);
    Run = 1'b1;
    run_cycles(30);

    async_reset();
    run_cycles(3);

    // Randomized segments
    for (int i = 0; i < 60; i++) begin
      Value   = 16'($urandom);
      DigitEn = 4'($urandom);
      LzSup   = 1'($urandom);
      if ($urandom_range(0, 3) == 0) Value[15:8] = 8'h00;
      Run     = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 11) == 0) async_reset();
      run_cycles(int'($urandom_range(1, 40)));
    end

    async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
